// File: rtl/uart_echo_ctl.sv
// uart_echo_ctl: Wishbone master that echoes UART RX bytes back to the same UART.
// On the RX interrupt it reads one byte into a 4-deep FIFO. When the TX gap has
// elapsed it writes the FIFO head back, so the UART transmitter is never overrun.
// Build option: define ECHO_UPCASE_EN to fold ASCII 'a'..'z' to 'A'..'Z' on receive.

module uart_echo_ctl #(
    parameter logic [31:0] UART_ADR    = 32'h0FF,
    parameter logic [15:0] TX_GAP      = 16'd25012,
    parameter logic [4:0]  ACK_TIMEOUT = 5'd16
) (
    input  logic        clk_48_i,
    input  logic        rst_i,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic        we_o,
    output logic        stb_o,
    output logic        cyc_o,
    output logic [3:0]  sel_o,
    input  logic        ack_i,
    input  logic        irq_i,
    output logic [2:0]  fifo_cnt_o,
    output logic        ovf_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RD   = 3'b010,
        WR   = 3'b100
    } state_t;

    state_t      state;
    logic [7:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [15:0] gap_cnt;
    logic [4:0]  tmo_cnt;
    logic        irq_stale;

    logic        ack_ok;
    logic        tmo_hit;
    logic        fifo_full;
    logic        fifo_empty;
    logic        rd_done;
    logic        wr_done;
    logic        push;
    logic [7:0]  rx_byte;
    logic        unused_dat;

    assign sel_o      = 4'b0001;
    assign unused_dat = ^dat_i[31:8];

    // Qualify ack (x/z count as 0, first cycle of a transfer ignored) and decode bus/FIFO events.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path keeps an old value and no latch is inferred.
        rx_byte = dat_i[7:0];
`ifdef ECHO_UPCASE_EN
        if (dat_i[7:0] >= 8'h61 && dat_i[7:0] <= 8'h7A)
            rx_byte = dat_i[7:0] - 8'h20;
`endif
        ack_ok     = (ack_i === 1'b1) && (tmo_cnt != 5'd0);
        tmo_hit    = (tmo_cnt == ACK_TIMEOUT - 5'd1);
        fifo_full  = (fifo_cnt_o == 3'd4);
        fifo_empty = (fifo_cnt_o == 3'd0);
        rd_done    = (state == RD) && ack_ok;
        wr_done    = (state == WR) && ack_ok;
        push       = rd_done && !fifo_full;
    end

    // FIFO storage, written only when a received byte is accepted.
    // NOTE: the data array is deliberately not reset; pointers and count define which entries are valid.
    always_ff @(posedge clk_48_i) begin
        if (push)
            fifo_mem[wr_ptr] <= rx_byte;
    end

    // Bus FSM with registered Wishbone outputs, FIFO pointers, gap pacing and sticky flags.
    always_ff @(posedge clk_48_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
            state      <= IDLE;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            we_o       <= 1'b0;
            adr_o      <= 32'h0;
            dat_o      <= 32'h0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_cnt_o <= 3'd0;
            gap_cnt    <= 16'd0;
            tmo_cnt    <= 5'd0;
            ovf_o      <= 1'b0;
            err_o      <= 1'b0;
            irq_stale  <= 1'b0;
        end else begin
            // Gap counter runs in every state so reads can proceed while TX is paced.
            if (wr_done)
                gap_cnt <= TX_GAP;
            else if (gap_cnt != 16'd0)
                gap_cnt <= gap_cnt - 16'd1;

            // An irq still high right after a read belongs to the byte just taken.
            if (rd_done)
                irq_stale <= 1'b1;
            else if (irq_i !== 1'b1)
                irq_stale <= 1'b0;

            case (state)
                IDLE: begin
                    tmo_cnt <= 5'd0;
                    if (irq_i === 1'b1 && !irq_stale) begin
                        state <= RD;
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        we_o  <= 1'b0;
                        adr_o <= UART_ADR;
                    end else if (!fifo_empty && gap_cnt == 16'd0) begin
                        state <= WR;
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        we_o  <= 1'b1;
                        adr_o <= UART_ADR;
                        dat_o <= {24'h0, fifo_mem[rd_ptr]};
                    end
                end
                RD, WR: begin
                    if (ack_ok || tmo_hit) begin
                        state <= IDLE;
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        adr_o <= 32'h0;
                        dat_o <= 32'h0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 5'd1;
                    end
                    if (push) begin
                        wr_ptr     <= wr_ptr + 2'd1;
                        fifo_cnt_o <= fifo_cnt_o + 3'd1;
                    end else if (rd_done) begin
                        ovf_o <= 1'b1;
                    end else if (wr_done) begin
                        rd_ptr     <= rd_ptr + 2'd1;
                        fifo_cnt_o <= fifo_cnt_o - 3'd1;
                    end else if (tmo_hit) begin
                        err_o <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cyc_o <= 1'b0;
                    stb_o <= 1'b0;
                    we_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_ctl.sv
// Directed bench for uart_echo_ctl: a small UART/Wishbone slave model and checks on
// reset state, single echo, overflow, ack timeout, TX pacing/order, reset mid-write
// and the ECHO_UPCASE_EN byte folding.

module tb_uart_echo_ctl;

    logic        clk_48_i = 1'b0;
    logic        rst_i    = 1'b0;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i    = 32'h0;
    logic        we_o;
    logic        stb_o;
    logic        cyc_o;
    logic [3:0]  sel_o;
    logic        ack_i    = 1'b0;
    logic        irq_i    = 1'b0;
    logic [2:0]  fifo_cnt_o;
    logic        ovf_o;
    logic        err_o;

`ifdef ECHO_UPCASE_EN
    localparam logic [7:0] EXP_B0   = 8'h42;  // RX 'b'
    localparam logic [7:0] EXP_POST = 8'h41;  // RX 'a'
`else
    localparam logic [7:0] EXP_B0   = 8'h62;
    localparam logic [7:0] EXP_POST = 8'h61;
`endif
    localparam logic [7:0] EXP_B1 = 8'h7B;    // just above 'z', unchanged
    localparam logic [7:0] EXP_B2 = 8'h60;    // just below 'a', unchanged

    uart_echo_ctl dut (
        .clk_48_i   (clk_48_i),
        .rst_i      (rst_i),
        .adr_o      (adr_o),
        .dat_o      (dat_o),
        .dat_i      (dat_i),
        .we_o       (we_o),
        .stb_o      (stb_o),
        .cyc_o      (cyc_o),
        .sel_o      (sel_o),
        .ack_i      (ack_i),
        .irq_i      (irq_i),
        .fifo_cnt_o (fifo_cnt_o),
        .ovf_o      (ovf_o),
        .err_o      (err_o)
    );

    always #5 clk_48_i = ~clk_48_i;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    always @(posedge clk_48_i) cyc_n++;

    // UART model state
    logic [7:0] rx_q [$];
    logic [7:0] wr_q [$];
    int         wr_t [$];
    bit         ack_en  = 1'b1;
    bit         in_wr   = 1'b0;
    bit         in_rd   = 1'b0;
    bit         just_rd = 1'b0;
    logic [7:0] wr_byte = 8'h0;

    // Slave model on the falling edge: logs completed writes, pops read bytes, drives irq/ack/data.
    always @(negedge clk_48_i) begin
        if (in_wr && !cyc_o) begin
            if (ack_en) begin
                wr_q.push_back(wr_byte);
                wr_t.push_back(cyc_n);
            end
            in_wr = 1'b0;
        end
        if (cyc_o && we_o) begin
            in_wr   = 1'b1;
            wr_byte = dat_o[7:0];
        end
        just_rd = 1'b0;
        if (in_rd && !cyc_o) begin
            if (ack_en && rx_q.size() > 0)
                void'(rx_q.pop_front());
            in_rd   = 1'b0;
            just_rd = 1'b1;
        end
        if (cyc_o && !we_o)
            in_rd = 1'b1;
        irq_i = (rx_q.size() > 0) && !just_rd;
        dat_i = (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'h0;
        ack_i = cyc_o && stb_o && ack_en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_48_i);
        #2;
    endtask

    function automatic logic [7:0] wr_at(input int i);
        return (wr_q.size() > i) ? wr_q[i] : 8'h00;
    endfunction

    function automatic int t_at(input int i);
        return (wr_t.size() > i) ? wr_t[i] : 0;
    endfunction

    // Bounded wait; an expired bound counts as a failed comparison.
    task automatic wait_until(input int sel, input int val, input int limit, input string tag);
        int  n   = 0;
        bit  hit = 1'b0;
        while (!hit && n < limit) begin
            case (sel)
                0:       hit = cyc_o && !we_o;
                1:       hit = cyc_o && we_o;
                2:       hit = (32'(fifo_cnt_o) == val);
                3:       hit = (rx_q.size() == 0);
                default: hit = (wr_q.size() == val);
            endcase
            if (!hit) begin
                tick();
                n++;
            end
        end
        if (!hit)
            check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int hi;
        #3 rst_i = 1'b1;
        tick();
        tick();
        check("rst_cyc", 32'(cyc_o), 32'd0);
        check("rst_stb", 32'(stb_o), 32'd0);
        check("rst_we",  32'(we_o),  32'd0);
        check("rst_adr", adr_o, 32'h0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_cnt", 32'(fifo_cnt_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_sel", 32'(sel_o), 32'h1);
        rst_i = 1'b0;
        tick();

        // Single echo of 'A'
        rx_q.push_back(8'h41);
        wait_until(0, 0, 20, "echo_rd");
        check("rd_adr", adr_o, 32'h0FF);
        wait_until(2, 1, 20, "echo_cnt1");
        check("echo_cnt1", 32'(fifo_cnt_o), 32'd1);
        wait_until(1, 0, 20, "echo_wr");
        check("wr_dat", dat_o, 32'h41);
        check("wr_adr", adr_o, 32'h0FF);
        wait_until(2, 0, 20, "echo_cnt0");
        check("echo_cnt0", 32'(fifo_cnt_o), 32'd0);
        check("echo_nwr", 32'(wr_q.size()), 32'd1);
        check("echo_byte", 32'(wr_at(0)), 32'h41);

        // Overflow: gap is now loaded, so five reads fill the FIFO and drop the fifth
        rx_q.push_back(8'h62);
        rx_q.push_back(8'h7B);
        rx_q.push_back(8'h60);
        rx_q.push_back(8'h7A);
        rx_q.push_back(8'h61);
        wait_until(3, 0, 100, "ovf_reads");
        tick();
        tick();
        check("ovf_cnt", 32'(fifo_cnt_o), 32'd4);
        check("ovf_flag", 32'(ovf_o), 32'd1);
        check("ovf_err", 32'(err_o), 32'd0);
        check("ovf_nwr", 32'(wr_q.size()), 32'd1);

        // Ack timeout on a read
        ack_en = 1'b0;
        rx_q.push_back(8'h55);
        wait_until(0, 0, 20, "tmo_rd");
        rx_q.delete();
        hi = 0;
        while (cyc_o && hi < 40) begin
            hi++;
            tick();
        end
        check("tmo_len", 32'(hi), 32'd16);
        check("tmo_err", 32'(err_o), 32'd1);
        check("tmo_cnt", 32'(fifo_cnt_o), 32'd4);
        ack_en = 1'b1;

        // Paced drain, then reset in the middle of the third drained write
        wait_until(4, 2, 26000, "drain1");
        wait_until(4, 3, 26000, "drain2");
        wait_until(1, 0, 26000, "drain3");
        check("d3_dat", dat_o, {24'h0, EXP_B2});
        check("d3_stb", 32'(stb_o), 32'd1);
        check("d3_cnt", 32'(fifo_cnt_o), 32'd2);
        check("d3_ovf", 32'(ovf_o), 32'd1);
        check("d3_err", 32'(err_o), 32'd1);
        ack_en = 1'b0;
        rst_i  = 1'b1;
        #1;
        check("mrst_cyc", 32'(cyc_o), 32'd0);
        check("mrst_stb", 32'(stb_o), 32'd0);
        check("mrst_we",  32'(we_o),  32'd0);
        check("mrst_adr", adr_o, 32'h0);
        check("mrst_dat", dat_o, 32'h0);
        check("mrst_cnt", 32'(fifo_cnt_o), 32'd0);
        check("mrst_ovf", 32'(ovf_o), 32'd0);
        check("mrst_err", 32'(err_o), 32'd0);

        check("ord_b0", 32'(wr_at(1)), 32'(EXP_B0));
        check("ord_b1", 32'(wr_at(2)), 32'(EXP_B1));
        check("pace_1", 32'(t_at(1) - t_at(0) >= 25012), 32'd1);
        check("pace_2", 32'(t_at(2) - t_at(1) >= 25012), 32'd1);

        tick();
        rst_i = 1'b0;
        tick();
        check("post_idle", 32'(cyc_o), 32'd0);
        ack_en = 1'b1;

        // Resume after reset: gap cleared, so the echo goes out at once
        rx_q.push_back(8'h61);
        wait_until(4, 4, 40, "post_echo");
        check("post_byte", 32'(wr_at(3)), 32'(EXP_POST));
        check("post_cnt", 32'(fifo_cnt_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
